grf_wport_arbiter: RTL and testbench

- Shares the single GRF write port between two requesters: the pipeline W stage and a long-latency result source such as the mult/div unit.
- Long-latency writes are parked in a 1-entry buffer and drained when the pipeline leaves the port idle.
- A starvation guard stalls the pipeline to force the drain.
- Also reports scoreboard busy flags for the registers held in the buffer, for hazard logic.

---
 rtl/grf_wport_arbiter_if.sv | 46 ++++
 rtl/grf_wport_arbiter.sv | 149 ++++++++++++++
 tb/tb_grf_wport_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_wport_arbiter_if.sv
// Handshake/bus bundle between the GRF write-port arbiter and its requesters.
// Groups the pipeline W-stage write, the long-latency producer handshake,
// the D-stage read addresses with their busy flags, the stall and the GRF write bus.
interface grf_wport_arbiter_if;
  // pipeline W-stage write request
  logic        p_wEn;
  logic [4:0]  p_wA;
  logic [31:0] p_wD;
  logic [31:0] p_pc;
  // long-latency producer (valid/ready)
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_wA;
  logic [31:0] m_wD;
  logic [31:0] m_pc;
  // D-stage hazard query
  logic [4:0]  rA1;
  logic [4:0]  rA2;
  logic        busy1;
  logic        busy2;
  // pipeline freeze
  logic        stall;
  // GRF write port
  logic        grf_wEn;
  logic [4:0]  grf_wA;
  logic [31:0] grf_wD;
  logic [31:0] grf_pc;

  // requester / environment side
  modport master (
    output p_wEn, p_wA, p_wD, p_pc,
    output m_valid, m_wA, m_wD, m_pc,
    output rA1, rA2,
    input  m_ready, busy1, busy2, stall,
    input  grf_wEn, grf_wA, grf_wD, grf_pc
  );

  // arbiter side
  modport slave (
    input  p_wEn, p_wA, p_wD, p_pc,
    input  m_valid, m_wA, m_wD, m_pc,
    input  rA1, rA2,
    output m_ready, busy1, busy2, stall,
    output grf_wEn, grf_wA, grf_wD, grf_pc
  );
endinterface

// File: rtl/grf_wport_arbiter.sv
// Shares the single GRF write port between the pipeline W stage and a long-latency producer.
// Latency: pipeline writes pass through combinationally (0 cycles); long-latency writes >=1 cycle.
// Backpressure: m_ready low while a write is parked; stall asserted for one cycle to force a drain.
//
// Ports: clk, reset (synchronous, active-low); bus (slave modport) carries the pipeline
// write, the m_valid/m_ready producer handshake, rA1/rA2 -> busy1/busy2, stall and grf_*.
// Optional: define GRF_ARB_STATS_EN to add stat_force / stat_squash saturating counters
// and a message on every forced drain.
module grf_wport_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
`ifdef GRF_ARB_STATS_EN
  output logic [15:0]         stat_force,
  output logic [15:0]         stat_squash,
`endif
  grf_wport_arbiter_if.slave  bus
);

  localparam int AW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_ba;
  logic [31:0] r_bd;
  logic [31:0] r_bpc;
  logic [AW-1:0] r_age, w_age_nxt;

  logic        w_p_req;
  logic        w_latch;
  logic        w_squash;
  logic        w_sel_pipe;
  logic        w_sel_buf;
  logic        w_m_ready;
  logic        w_stall;

  // A write to $0 is architecturally a no-op, so it does not claim the port.
  assign w_p_req = bus.p_wEn && (bus.p_wA != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_age   <= '0;
      r_ba    <= '0;
      r_bd    <= '0;
      r_bpc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
      if (w_latch) begin
        r_ba  <= bus.m_wA;
        r_bd  <= bus.m_wD;
        r_bpc <= bus.m_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_age_nxt   = r_age;
    w_latch     = 1'b0;
    w_squash    = 1'b0;
    w_sel_pipe  = 1'b0;
    w_sel_buf   = 1'b0;
    w_m_ready   = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_m_ready  = 1'b1;
        w_sel_pipe = w_p_req;
        // $0 results are accepted and dropped without occupying the buffer.
        if (bus.m_valid && (bus.m_wA != 5'd0)) begin
          w_latch     = 1'b1;
          w_age_nxt   = '0;
          w_state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!w_p_req) begin
          w_sel_buf   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (bus.p_wA == r_ba) begin
          // The pipeline write is younger; the parked value is dead.
          w_sel_pipe  = 1'b1;
          w_squash    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_sel_pipe = 1'b1;
          w_age_nxt  = r_age + AW'(1);
          if (r_age == AW'(STARVE_LIMIT - 1)) begin
            w_state_nxt = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        w_stall     = 1'b1;
        w_sel_buf   = 1'b1;
        w_age_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_age_nxt   = '0;
      end
    endcase
  end

  assign bus.m_ready = w_m_ready;
  assign bus.stall   = w_stall;
  assign bus.grf_wEn = w_sel_pipe | w_sel_buf;
  assign bus.grf_wA  = w_sel_pipe ? bus.p_wA : (w_sel_buf ? r_ba  : 5'd0);
  assign bus.grf_wD  = w_sel_pipe ? bus.p_wD : (w_sel_buf ? r_bd  : 32'd0);
  assign bus.grf_pc  = w_sel_pipe ? bus.p_pc : (w_sel_buf ? r_bpc : 32'd0);

  // Busy covers both HELD and FORCE: the value is not yet in the GRF in either.
  assign bus.busy1 = (r_state != ST_IDLE) && (r_ba == bus.rA1) && (bus.rA1 != 5'd0);
  assign bus.busy2 = (r_state != ST_IDLE) && (r_ba == bus.rA2) && (bus.rA2 != 5'd0);

`ifdef GRF_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_force  <= '0;
      stat_squash <= '0;
    end else begin
      if ((r_state == ST_FORCE) && (stat_force != 16'hFFFF)) begin
        stat_force <= stat_force + 16'd1;
      end
      if (w_squash && (stat_squash != 16'hFFFF)) begin
        stat_squash <= stat_squash + 16'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && (r_state == ST_FORCE)) begin
      $display("%d@%h: arb force $%d", $time, r_bpc, r_ba);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wport_arbiter_if bus_if ();

`ifdef GRF_ARB_STATS_EN
  logic [15:0] stat_force;
  logic [15:0] stat_squash;
`endif

  grf_wport_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef GRF_ARB_STATS_EN
    .stat_force  (stat_force),
    .stat_squash (stat_squash),
`endif
    .bus         (bus_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int wr_cnt [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One parked write at most; it loses to the pipeline a bounded number of
  // times, after which one cycle is spent writing it with the pipeline frozen.
  bit          md_pend;
  logic [4:0]  md_a;
  logic [31:0] md_d, md_pc;
  int          md_loss;
  bit          md_frc;
  int          md_nforce, md_nsq;

  function automatic bit preq();
    return bus_if.p_wEn && (bus_if.p_wA != 5'd0);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      md_pend = 0; md_a = 0; md_d = 0; md_pc = 0;
      md_loss = 0; md_frc = 0; md_nforce = 0; md_nsq = 0;
    end else if (!md_pend) begin
      if (bus_if.m_valid && bus_if.m_wA != 5'd0) begin
        md_pend = 1; md_a = bus_if.m_wA; md_d = bus_if.m_wD; md_pc = bus_if.m_pc;
        md_loss = 0;
      end
    end else if (md_frc) begin
      md_pend = 0; md_frc = 0; md_nforce++;
    end else if (!preq()) begin
      md_pend = 0;
    end else if (bus_if.p_wA == md_a) begin
      md_pend = 0; md_nsq++;
    end else begin
      md_loss++;
      if (md_loss == STARVE_LIMIT) md_frc = 1;
    end
  end

  logic        e_wen, e_stall, e_mrdy, e_b1, e_b2;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_pc;

  always @(negedge clk) begin
    if (chk_en) begin
      e_wen = 0; e_wa = 0; e_wd = 0; e_pc = 0; e_stall = 0; e_mrdy = 0;
      if (!md_pend) begin
        e_mrdy = 1;
        if (preq()) begin
          e_wen = 1; e_wa = bus_if.p_wA; e_wd = bus_if.p_wD; e_pc = bus_if.p_pc;
        end
      end else if (md_frc || !preq()) begin
        e_stall = md_frc;
        e_wen = 1; e_wa = md_a; e_wd = md_d; e_pc = md_pc;
      end else begin
        e_wen = 1; e_wa = bus_if.p_wA; e_wd = bus_if.p_wD; e_pc = bus_if.p_pc;
      end
      e_b1 = md_pend && (md_a == bus_if.rA1) && (bus_if.rA1 != 5'd0);
      e_b2 = md_pend && (md_a == bus_if.rA2) && (bus_if.rA2 != 5'd0);
      chk("mdl_wen",   32'(bus_if.grf_wEn), 32'(e_wen));
      chk("mdl_wa",    32'(bus_if.grf_wA),  32'(e_wa));
      chk("mdl_wd",    bus_if.grf_wD,       e_wd);
      chk("mdl_pc",    bus_if.grf_pc,       e_pc);
      chk("mdl_stall", 32'(bus_if.stall),   32'(e_stall));
      chk("mdl_mrdy",  32'(bus_if.m_ready), 32'(e_mrdy));
      chk("mdl_busy1", 32'(bus_if.busy1),   32'(e_b1));
      chk("mdl_busy2", 32'(bus_if.busy2),   32'(e_b2));
      chk("no_wr_r0",  32'(bus_if.grf_wEn && bus_if.grf_wA == 5'd0), 32'd0);
`ifdef GRF_ARB_STATS_EN
      chk("mdl_stat_force",  32'(stat_force),  32'(md_nforce));
      chk("mdl_stat_squash", 32'(stat_squash), 32'(md_nsq));
`endif
      if (bus_if.grf_wEn === 1'b1) wr_cnt[bus_if.grf_wA]++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_m(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus_if.m_valid = v; bus_if.m_wA = a; bus_if.m_wD = d; bus_if.m_pc = pc;
  endtask

  task automatic drive_p(input logic en, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus_if.p_wEn = en; bus_if.p_wA = a; bus_if.p_wD = d; bus_if.p_pc = pc;
  endtask

  initial begin
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    reset = 1'b0;
    drive_m(0, 0, 0, 0);
    drive_p(0, 0, 0, 0);
    bus_if.rA1 = 5'd5;
    bus_if.rA2 = 5'd0;
    cyc();
    chk_en = 1'b1;
    // reset state
    mid();
    chk("rst_mrdy",  32'(bus_if.m_ready), 32'd1);
    chk("rst_stall", 32'(bus_if.stall),   32'd0);
    chk("rst_wen",   32'(bus_if.grf_wEn), 32'd0);
    chk("rst_busy1", 32'(bus_if.busy1),   32'd0);
    cyc();
    reset = 1'b1;

    // idle drain
    drive_m(1, 5'd8, 32'h1234, 32'h100);
    mid();
    chk("drain_c0_mrdy", 32'(bus_if.m_ready), 32'd1);
    chk("drain_c0_wen",  32'(bus_if.grf_wEn), 32'd0);
    cyc();
    drive_m(0, 0, 0, 0);
    mid();
    chk("drain_c1_wen", 32'(bus_if.grf_wEn), 32'd1);
    chk("drain_c1_wa",  32'(bus_if.grf_wA),  32'd8);
    chk("drain_c1_wd",  bus_if.grf_wD,       32'h1234);
    chk("drain_c1_pc",  bus_if.grf_pc,       32'h100);
    cyc();
    mid();
    chk("drain_c2_mrdy", 32'(bus_if.m_ready), 32'd1);

    // starvation: four pipeline wins, one forced drain, then the retry
    cyc();
    drive_m(1, 5'd9, 32'h99, 32'h200);
    cyc();
    drive_m(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] pa;
      case (i)
        0: pa = 5'd3;
        1: pa = 5'd4;
        2: pa = 5'd6;
        default: pa = 5'd7;
      endcase
      drive_p(1, pa, 32'h300 + i, 32'h400 + i);
      mid();
      chk("starve_pipe_wa",    32'(bus_if.grf_wA), 32'(pa));
      chk("starve_pipe_stall", 32'(bus_if.stall),  32'd0);
      cyc();
    end
    drive_p(1, 5'd11, 32'hB11, 32'h500);
    mid();
    chk("force_stall", 32'(bus_if.stall),  32'd1);
    chk("force_wa",    32'(bus_if.grf_wA), 32'd9);
    chk("force_wd",    bus_if.grf_wD,      32'h99);
    cyc();
    mid();
    chk("retry_stall", 32'(bus_if.stall),  32'd0);
    chk("retry_wa",    32'(bus_if.grf_wA), 32'd11);
    chk("retry_wd",    bus_if.grf_wD,      32'hB11);
    cyc();
    drive_p(0, 0, 0, 0);

    // squash
    drive_m(1, 5'd10, 32'hAAAA, 32'h600);
    bus_if.rA1 = 5'd10;
    cyc();
    drive_m(0, 0, 0, 0);
    drive_p(1, 5'd10, 32'hBBBB, 32'h700);
    mid();
    chk("squash_busy", 32'(bus_if.busy1),  32'd1);
    chk("squash_wa",   32'(bus_if.grf_wA), 32'd10);
    chk("squash_wd",   bus_if.grf_wD,      32'hBBBB);
    cyc();
    drive_p(0, 0, 0, 0);
    mid();
    chk("squash_busy_clr", 32'(bus_if.busy1),   32'd0);
    chk("squash_no_drain", 32'(bus_if.grf_wEn), 32'd0);
    cyc();
    mid();
    chk("squash_wr10_once", 32'(wr_cnt[10]), 32'd1);
`ifdef GRF_ARB_STATS_EN
    chk("stat_squash_1", 32'(stat_squash), 32'd1);
    chk("stat_force_1",  32'(stat_force),  32'd1);
`endif

    // $0 handling
    cyc();
    drive_m(1, 5'd0, 32'hDEAD, 32'h800);
    mid();
    chk("m0_mrdy", 32'(bus_if.m_ready), 32'd1);
    cyc();
    drive_m(0, 0, 0, 0);
    mid();
    chk("m0_still_idle", 32'(bus_if.m_ready), 32'd1);
    chk("m0_no_write",   32'(bus_if.grf_wEn), 32'd0);
    cyc();
    drive_m(1, 5'd13, 32'h1313, 32'h900);
    cyc();
    drive_m(0, 0, 0, 0);
    drive_p(1, 5'd0, 32'hFFFF, 32'hA00);
    mid();
    chk("p0_drain_wen", 32'(bus_if.grf_wEn), 32'd1);
    chk("p0_drain_wa",  32'(bus_if.grf_wA),  32'd13);
    chk("p0_drain_wd",  bus_if.grf_wD,       32'h1313);
    cyc();
    drive_p(0, 0, 0, 0);
    mid();
    chk("p0_after_mrdy", 32'(bus_if.m_ready), 32'd1);

    // busy flags
    cyc();
    bus_if.rA1 = 5'd12;
    bus_if.rA2 = 5'd0;
    drive_m(1, 5'd12, 32'h1212, 32'hB00);
    cyc();
    drive_m(0, 0, 0, 0);
    drive_p(1, 5'd3, 32'h3, 32'hC00);
    mid();
    chk("busy_b1", 32'(bus_if.busy1), 32'd1);
    chk("busy_b2", 32'(bus_if.busy2), 32'd0);
    cyc();
    drive_p(0, 0, 0, 0);
    mid();
    chk("busy_drain_wa", 32'(bus_if.grf_wA), 32'd12);
    cyc();
    mid();
    chk("busy_b1_clr", 32'(bus_if.busy1), 32'd0);
    chk("busy_b2_clr", 32'(bus_if.busy2), 32'd0);

    // reset while HELD discards the parked write
    cyc();
    bus_if.rA1 = 5'd5;
    drive_m(1, 5'd5, 32'h5555, 32'hD00);
    cyc();
    drive_m(0, 0, 0, 0);
    drive_p(1, 5'd3, 32'h33, 32'hE00);
    reset = 1'b0;
    mid();
    chk("rsth_busy_before", 32'(bus_if.busy1),  32'd1);
    chk("rsth_pipe_wa",     32'(bus_if.grf_wA), 32'd3);
    cyc();
    reset = 1'b1;
    drive_p(0, 0, 0, 0);
    mid();
    chk("rsth_busy_after", 32'(bus_if.busy1),   32'd0);
    chk("rsth_mrdy",       32'(bus_if.m_ready), 32'd1);
    chk("rsth_wen",        32'(bus_if.grf_wEn), 32'd0);
    cyc();
    cyc();
    mid();
    chk("rsth_r5_never", 32'(wr_cnt[5]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
